// File: rtl/imem_sync.sv
// Synchronous byte-addressed instruction memory with a registered, handshaked read port and a word load port.
// Optional build macro IMEM_ALIGN_CHECK_EN: flags misaligned fetches and drops misaligned loads.
module imem_sync #(
  parameter int    ADDR_BUS_WIDTH = 16,
  parameter int    DATA_BUS_WIDTH = 32,
  parameter int    MEM_BYTES      = 4096,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BUS_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  input  logic                      load_en,
  input  logic [ADDR_BUS_WIDTH-1:0] load_addr,
  input  logic [DATA_BUS_WIDTH-1:0] load_data
);

  localparam int BPW   = DATA_BUS_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_BYTES);

  typedef enum logic {IDLE, VALID} state_t;

  logic [7:0]                mem [MEM_BYTES];
  state_t                    state, state_nx;
  logic                      accept;
  logic                      req_mis, load_mis;
  logic [DATA_BUS_WIDTH-1:0] data_p1;
  logic                      err_p1;
  logic                      unused_addr;

  // Only the low IDX_W address bits select a byte; the rest alias.
  assign unused_addr = ^{req_addr, load_addr};

  // Big-endian gather: byte at addr lands in the MSB, wrapping at the top of memory.
  function automatic logic [DATA_BUS_WIDTH-1:0] read_word(input logic [ADDR_BUS_WIDTH-1:0] a);
    logic [DATA_BUS_WIDTH-1:0] w;
    logic [IDX_W-1:0]          base;
    w    = '0;
    base = a[IDX_W-1:0];
    for (int i = 0; i < BPW; i++) begin
      w[DATA_BUS_WIDTH-1-8*i -: 8] = mem[base + IDX_W'(i)];
    end
    return w;
  endfunction

`ifdef IMEM_ALIGN_CHECK_EN
  assign req_mis  = (req_addr  % ADDR_BUS_WIDTH'(BPW)) != '0;
  assign load_mis = (load_addr % ADDR_BUS_WIDTH'(BPW)) != '0;
`else
  assign req_mis  = 1'b0;
  assign load_mis = 1'b0;
`endif

  assign rsp_valid = (state == VALID);
  assign req_ready = !load_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_data  = data_p1;
  assign rsp_err   = err_p1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = VALID;
      VALID:   if (rsp_ready && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // p1: response register, loaded from the array at the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (accept) begin
      data_p1 <= req_mis ? '0 : read_word(req_addr);
      err_p1  <= req_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !reset && !load_mis) begin
      for (int i = 0; i < BPW; i++) begin
        mem[load_addr[IDX_W-1:0] + IDX_W'(i)] <= load_data[DATA_BUS_WIDTH-1-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_imem_sync;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MEM = 4096;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
  logic [AW-1:0] req_addr, load_addr;
  logic [DW-1:0] rsp_data, load_data;

  rsp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  imem_sync #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .MEM_BYTES(MEM), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Monitor: a transfer completes on the coming edge when valid & ready; while held, the front must stay put.
  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid, rsp_data}, 64'd0);
      end else if (rsp_ready) begin
        rsp_t r;
        r = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(r.data));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
      end else begin
        chk("hold_data", 64'(rsp_data), 64'(exp_q[0].data));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = '0;
    rsp_ready = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;

    // Reset held two cycles with a request pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_valid", 64'(rsp_valid), 64'd0);
      chk("reset_data", 64'(rsp_data), 64'd0);
      chk("reset_err", 64'(rsp_err), 64'd0);
    end
    step();
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    step();

    // Load then back-to-back reads
    load(16'h0000, 32'hFFC4A303);
    load(16'h0004, 32'h00030000);
    req_valid = 1'b1; req_addr = 16'h0000; push(32'hFFC4A303, 1'b0);
    step();
    req_addr = 16'h0004; push(32'h00030000, 1'b0);
    step();
    req_valid = 1'b0;
    step(); step();

    // Backpressure
    req_valid = 1'b1; req_addr = 16'h0000; push(32'hFFC4A303, 1'b0);
    step();
    rsp_ready = 1'b0; req_addr = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1; push(32'h00030000, 1'b0);
    step();
    req_valid = 1'b0;
    step(); step();

    // Wrap-around at the top of memory
    load(16'(MEM - 4), 32'h11223344);
    load(16'h0000, 32'h55667788);
    req_valid = 1'b1; req_addr = 16'(MEM - 2);
`ifdef IMEM_ALIGN_CHECK_EN
    push(32'h00000000, 1'b1);
`else
    push(32'h33445566, 1'b0);
`endif
    step();
    req_valid = 1'b0;
    step(); step();

    // Load takes priority over a same-cycle request
    load_en = 1'b1; load_addr = 16'h0008; load_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 16'h0008;
    #1;
    chk("prio_req_ready", 64'(req_ready), 64'd0);
    step();
    load_en = 1'b0; push(32'hDEADBEEF, 1'b0);
    #1;
    chk("post_load_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    step(); step();

    // Reset while a response is held
    req_valid = 1'b1; req_addr = 16'h0004; push(32'h00030000, 1'b0);
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    exp_q.delete();
    @(negedge clk);
    chk("midreset_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_data", 64'(rsp_data), 64'd0);
    step();
    reset = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 16'h0004; push(32'h00030000, 1'b0);
    step();
    req_addr = 16'h0008; push(32'hDEADBEEF, 1'b0);
    step();
    req_valid = 1'b0;
    step(); step(); step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
